// File: rtl/sigmoid_grad.sv
// Sigmoid backward pass: dx[i] = g[i] * y[i] * (1 - y[i]) on float32 elements,
// one element at a time through a shared subtract stage and a shared multiplier.
module sigmoid_grad #(
  parameter int S = 32,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [S*N-1:0] y,
  input  logic [S*N-1:0] g,
  input  logic         start,
  output logic [S*N-1:0] dx,
  output logic         done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SUB, MUL1, MUL2} state_t;

  state_t             r_state, w_next;
  logic [N-1:0][S-1:0] r_y, r_g, r_dx;
  logic [IW-1:0]      r_idx;
  logic [31:0]        r_t, r_p;
  logic               r_done;

  logic               w_load, w_sub_en, w_mul1_en, w_mul2_en, w_last;
  logic [31:0]        w_t, w_p, w_dx;

  // 1 - a, exact difference truncated toward zero to 24 significand bits.
  // a is scaled to a 24-bit fraction; any bits shifted out borrow one ulp.
  function automatic logic [31:0] f_one_minus(input logic [31:0] a);
    logic [7:0]  e;
    logic [23:0] m;
    logic [6:0]  sh;
    logic [47:0] w;
    logic [23:0] yf;
    logic        st;
    logic [24:0] d;
    logic [24:0] dn;
    int          p;
    e = a[30:23];
    m = {1'b1, a[22:0]};
    if (e == 8'd0)   return 32'h3F80_0000;
    if (e >= 8'd127) return 32'h0000_0000;
    sh = 7'(8'd126 - e);
    if (sh >= 7'd24) begin
      yf = '0;
      st = 1'b1;
    end else begin
      w  = {m, 24'b0} >> sh;
      yf = w[47:24];
      st = |w[23:0];
    end
    d = 25'h100_0000 - {1'b0, yf} - {24'b0, st};
    p = 0;
    for (int i = 0; i < 25; i++)
      if (d[i]) p = i;
    dn = d << (24 - p);
    return {1'b0, 8'(p + 103), dn[23:1]};
  endfunction

  // Truncating float32 multiply; zero/denormal operands give +0,
  // underflow flushes to +0, overflow saturates to max finite.
  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        pr;
    logic signed [9:0]  ex;
    logic [22:0]        mt;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0000_0000;
    s  = a[31] ^ b[31];
    pr = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    ex = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
    if (pr[47]) begin
      mt = pr[46:24];
      ex = ex + 10'sd1;
    end else begin
      mt = pr[45:23];
    end
    if (ex < 10'sd1)   return 32'h0000_0000;
    if (ex > 10'sd254) return {s, 31'h7F7F_FFFF};
    return {s, ex[7:0], mt};
  endfunction

  // y with sign dropped, denormals flushed, and anything >= 1.0 clamped to 1.0
  function automatic logic [31:0] f_ysan(input logic [31:0] a);
    if (a[30:23] == 8'd0)   return 32'h0000_0000;
    if (a[30:23] >= 8'd127) return 32'h3F80_0000;
    return {1'b0, a[30:0]};
  endfunction

  assign w_last = (r_idx == IW'(N - 1));
  assign w_t    = f_one_minus(r_y[r_idx]);
  assign w_p    = f_mul(f_ysan(r_y[r_idx]), r_t);
  assign w_dx   = f_mul(r_p, r_g[r_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SUB;
      SUB:     w_next = MUL1;
      MUL1:    w_next = MUL2;
      MUL2:    w_next = w_last ? IDLE : SUB;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_sub_en  = 1'b0;
    w_mul1_en = 1'b0;
    w_mul2_en = 1'b0;
    case (r_state)
      IDLE:    w_load    = start;
      SUB:     w_sub_en  = 1'b1;
      MUL1:    w_mul1_en = 1'b1;
      MUL2:    w_mul2_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y    <= '0;
      r_g    <= '0;
      r_dx   <= '0;
      r_idx  <= '0;
      r_t    <= '0;
      r_p    <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_y    <= y;
        r_g    <= g;
        r_idx  <= '0;
        r_dx   <= '0;
        r_done <= 1'b0;
      end
      if (w_sub_en)  r_t <= w_t;
      if (w_mul1_en) r_p <= w_p;
      if (w_mul2_en) begin
        r_dx[r_idx] <= w_dx;
        if (w_last) r_done <= 1'b1;
        else        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign dx   = r_dx;
  assign done = r_done;

endmodule

// File: tb/tb_sigmoid_grad.sv
// Bench for sigmoid_grad: directed vector table, busy/reset/hold sequences,
// and random vectors against a double-precision reference with explicit truncation.
module tb_sigmoid_grad;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] y = '0, g = '0;
  logic        start = 1'b0;
  logic [63:0] dx;
  logic        done;

  int checks = 0;
  int errors = 0;

  sigmoid_grad #(.S(32), .N(2)) dut (
    .clk(clk), .rst(rst), .y(y), .g(g), .start(start), .dx(dx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] y;
    logic [63:0] g;
    logic [63:0] dx;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // float32 bits -> real, denormals read as zero
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  // real -> float32 truncating toward zero, flush underflow, saturate overflow
  function automatic logic [31:0] r2f(input real v);
    logic [63:0] b;
    int          e;
    if (v == 0.0) return 32'h0;
    b = $realtobits(v);
    e = int'(b[62:52]) - 896;
    if (e < 1)   return 32'h0;
    if (e > 254) return {b[63], 31'h7F7F_FFFF};
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic logic [31:0] ref_elem(input logic [31:0] yv, input logic [31:0] gv);
    real         ys;
    logic [31:0] t, p;
    if (yv[30:23] == 8'd0)        ys = 0.0;
    else if (yv[30:23] >= 8'd127) ys = 1.0;
    else                          ys = f2r({1'b0, yv[30:0]});
    t = r2f(1.0 - ys);
    p = r2f(ys * f2r(t));
    return r2f(f2r(p) * f2r(gv));
  endfunction

  task automatic run_vec(input logic [63:0] yv, input logic [63:0] gv,
                         output logic [63:0] dxo, output int lat);
    @(negedge clk);
    y = yv; g = gv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    y = {$urandom, $urandom};
    g = {$urandom, $urandom};
    chk("done_clear_on_start", {63'b0, done}, 64'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    dxo = dx;
  endtask

  vec_t        tbl[8];
  logic [63:0] res;
  int          lat;
  logic        ok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{64'h3F400000_3F000000, 64'hC0000000_3F800000, 64'hBEC00000_3E800000};
    tbl[1] = '{64'h3F800000_00000000, 64'h40A00000_40A00000, 64'h00000000_00000000};
    tbl[2] = '{64'h3F000000_BF000000, 64'h3F800000_3F800000, 64'h3E800000_3E800000};
    tbl[3] = '{64'h3F7FFFFF_3F000000, 64'h3F800000_3F800000, 64'h337FFFFF_3E800000};
    tbl[4] = '{64'h3F000000_3F000000, 64'h7F7FFFFF_00400000, 64'h7E7FFFFF_00000000};
    tbl[5] = '{64'h33000000_33800000, 64'h3F800000_3F800000, 64'h32FFFFFF_337FFFFF};
    tbl[6] = '{64'h40000000_00000001, 64'hBF800000_3F800000, 64'h00000000_00000000};
    tbl[7] = '{64'h3E800000_3E800000, 64'hC0800000_40800000, 64'hBF400000_3F400000};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dx", dx, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i].y, tbl[i].g, res, lat);
      chk($sformatf("tbl%0d_dx", i), res, tbl[i].dx);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd6);
    end

    // start while busy must be ignored; done and dx hold afterwards
    @(negedge clk);
    y = tbl[0].y; g = tbl[0].g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    y = tbl[4].y; g = tbl[4].g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_latency", 64'(lat), 64'd6);
    chk("busy_dx", dx, tbl[0].dx);
    ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (!done || dx !== tbl[0].dx) ok = 1'b0;
    end
    chk("done_hold", {63'b0, ok}, 64'd1);
    run_vec(tbl[4].y, tbl[4].g, res, lat);
    chk("after_hold_dx", res, tbl[4].dx);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    y = tbl[0].y; g = tbl[0].g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_dx0", {32'b0, dx[31:0]}, 64'h3E800000);
    rst = 1'b1;
    #1;
    chk("async_rst_dx", dx, 64'd0);
    chk("async_rst_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || dx !== 64'd0) ok = 1'b0;
    end
    chk("idle_after_rst", {63'b0, ok}, 64'd1);
    run_vec(tbl[0].y, tbl[0].g, res, lat);
    chk("post_rst_dx", res, tbl[0].dx);
    chk("post_rst_latency", 64'(lat), 64'd6);

    // random vectors against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [63:0] yv, gv, ex;
      for (int k = 0; k < 2; k++) begin
        logic [7:0] ye, ge;
        if ($urandom_range(0, 7) == 0)
          ye = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(127, 130));
        else
          ye = 8'($urandom_range(97, 126));
        ge = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
        yv[32*k +: 32] = {1'($urandom), ye, 23'($urandom)};
        gv[32*k +: 32] = {1'($urandom), ge, 23'($urandom)};
        ex[32*k +: 32] = ref_elem(yv[32*k +: 32], gv[32*k +: 32]);
      end
      run_vec(yv, gv, res, lat);
      chk($sformatf("rand%0d_dx y=%h g=%h", r, yv, gv), res, ex);
      chk($sformatf("rand%0d_latency", r), 64'(lat), 64'd6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
